bimodal_btb_predictor: RTL and testbench
========================================

Name: bimodal_btb_predictor

Overview:
- Parametrised branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with a per-entry saturating direction counter.
- Replaces the fixed single-entry predictor scheme. Entry count, counter width and index alignment are generics.
- Adds a table-clearing init sweep, a flush, and jump-always-taken entries.
- Fetch reads predictions combinationally. The execute/branch-resolution stage writes updates.

Parameters:
- NUM_ENTRIES, 64, BTB depth; power of two, >= 2. IDX_BITS = $clog2(NUM_ENTRIES).
- CTR_BITS, 2, width of the saturating direction counter; >= 1.
- INDEX_LSB, 2, lowest PC bit used for the index. Set to 1 when RV32C is supported.
- RAS_DEPTH, 8, return-stack depth; power of two. Used only with RAS_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- flush  in  1  pulse; invalidates every entry via the init sweep
- ready  out  1  table initialised; predictions and updates live
- current_pc  in  32  fetch PC to look up
- predict_taken  out  1  predicted taken for current_pc
- target_addr  out  32  predicted target; 0 when predict_taken=0
- update_predictor  in  1  resolution valid this cycle
- pc_to_update  in  32  PC of the resolved control-flow instruction
- branch_result  in  1  actual direction (1 = taken)
- update_addr  in  32  actual target
- is_jump  in  1  resolved instruction is an unconditional jump
- ras_push  in  1  call fetched; push ras_push_addr (RAS_EN only)
- ras_push_addr  in  32  return address to push
- ras_pop  in  1  current_pc is a return; use and pop top of stack

Behaviour:
- Entry fields: valid, jump, tag = pc[31:INDEX_LSB+IDX_BITS], target[31:0], ctr[CTR_BITS-1:0].
- Index = pc[INDEX_LSB +: IDX_BITS].
- FSM states: INIT, RUN.
- RST=1 at a clock edge → INIT, sweep_idx=0, ready=0, predict_taken=0, target_addr=0. RST asserted mid-operation restarts the sweep.
- INIT: each cycle clears valid[sweep_idx] and increments sweep_idx. After clearing NUM_ENTRIES-1 → RUN, with ready=1 on the next cycle. Init therefore takes exactly NUM_ENTRIES cycles.
- In INIT, updates are ignored and the prediction outputs stay 0.
- flush=1 in any state → INIT, sweep_idx=0. flush has priority over a same-cycle update.
- RUN lookup is combinational, with zero-cycle latency from current_pc. hit = valid & (tag == current_pc tag).
- predict_taken = hit & (jump | ctr[MSB]). target_addr = predict_taken ? target : 0.
- RUN update on update_predictor is written at the clock edge and is visible from the next cycle. A same-cycle lookup of the same index sees the old contents; there is no bypass.
  - Hit, is_jump: ctr = all ones, jump = 1, target = update_addr.
  - Hit, branch: ctr increments when branch_result=1, saturating at 2^CTR_BITS-1. It decrements when branch_result=0, saturating at 0. target is rewritten only when branch_result=1.
  - Miss with branch_result=1 or is_jump=1: allocate, overwriting any occupant. Set valid=1, the new tag, target = update_addr, jump = is_jump. ctr = is_jump ? all ones : 1<<(CTR_BITS-1) (weakly taken).
  - Miss with branch_result=0 and is_jump=0: no change.
- CTR_BITS=1 degenerates to last-direction prediction.

Optional Feature:
- Macro: BTB_RAS_EN. When defined, a RAS_DEPTH-entry circular return stack is instantiated.
  - ras_push writes ras_push_addr at top+1. On overflow it wraps and overwrites the oldest entry; count saturates at RAS_DEPTH.
  - ras_pop with count>0: predict_taken=1 and target_addr = top, overriding the BTB. The stack pops at the clock edge.
  - ras_pop with count=0: falls back to the BTB; no pointer change.
  - Simultaneous push and pop: the top entry is replaced; count unchanged.
  - RST and flush empty the stack.
- When undefined: ras_* inputs exist but are ignored; no stack storage is built.

Decomposition:
- Package branch_pred_pkg: btb_entry_t struct, typedef enum {INIT, RUN} bp_state_t, WEAK_TAKEN function of CTR_BITS.
- Sub-module return_addr_stack (RAS_DEPTH), instantiated only under BTB_RAS_EN.

Test Plan:
- RST 1 cycle, NUM_ENTRIES=64 → ready rises exactly 64 cycles after reset deassert. current_pc=0x100 during INIT → predict_taken=0, target_addr=0.
- Update pc=0x100, taken, target 0x200 → next cycle lookup 0x100 gives predict_taken=1, target 0x200. Then two not-taken updates → ctr 2→1→0 and predict_taken=0. A third not-taken update keeps ctr at 0.
- Aliasing: allocate 0x100 (taken), then update 0x500 taken (same index for 64 entries, INDEX_LSB=2) → lookup 0x100 misses, 0x500 hits. Not-taken update to a missing PC → no allocation.
- Jump at 0x300 → 0x40 allocated. Then three not-taken branch updates for 0x300 → predict_taken stays 1 (jump bit).
- Update and lookup of 0x100 in the same cycle → old prediction that cycle, new one the next. flush with a concurrent update → update dropped, ready=0 for 64 cycles.
- BTB_RAS_EN: push 0x10, 0x20; ras_pop → target 0x20, then 0x10; third pop → BTB result. Push 9 entries into depth 8 → oldest lost.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the bimodal BTB branch predictor.
//   bp_state_t  : table state (INIT sweep / RUN)
//   btb_entry_t : one BTB line. The tag and ctr fields are sized for the
//                 widest legal configuration (tag 32 bits, ctr up to
//                 CTR_MAX_BITS). Narrower configurations zero-extend into them.
//   weak_taken  : counter value that means "weakly taken" for a given width
//   ctr_ones    : saturated (strongly taken) counter value for a given width
package branch_pred_pkg;

  localparam int CTR_MAX_BITS = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  typedef struct packed {
    logic                    valid;
    logic                    jump;
    logic [31:0]             tag;
    logic [31:0]             target;
    logic [CTR_MAX_BITS-1:0] ctr;
  } btb_entry_t;

  function automatic logic [CTR_MAX_BITS-1:0] weak_taken(input int ctr_bits);
    logic [CTR_MAX_BITS-1:0] one;
    one = CTR_MAX_BITS'(1);
    return one << (ctr_bits - 1);
  endfunction

  // For ctr_bits == CTR_MAX_BITS the shift yields 0, and 0-1 gives all ones.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_ones(input int ctr_bits);
    logic [CTR_MAX_BITS-1:0] one;
    one = CTR_MAX_BITS'(1);
    return (one << ctr_bits) - one;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack used for predicting function returns.
// This module is built only when BTB_RAS_EN is defined in the predictor top.
//   clk, srst  : clock and synchronous active-high clear (empties the stack)
//   push       : write push_addr above the current top
//   pop        : drop the top entry (ignored while empty)
//   push_addr  : return address to store
//   valid      : stack holds at least one entry
//   top_addr   : current top entry (meaningful only while valid)
// RAS_DEPTH must be a power of two >= 2. When the stack is full, a push wraps
// the pointer and overwrites the oldest entry, and the count saturates.
module return_addr_stack #(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic        valid,
  output logic [31:0] top_addr
);

  localparam int PTR_BITS = $clog2(RAS_DEPTH);

  logic [31:0]         stack_mem [RAS_DEPTH];
  logic [PTR_BITS-1:0] top_reg, top_next;
  logic [PTR_BITS:0]   count_reg, count_next;
  logic [PTR_BITS-1:0] wr_ptr;
  logic                pop_eff;
  logic                full;

  assign valid    = (count_reg != '0);
  assign full     = (count_reg == (PTR_BITS+1)'(RAS_DEPTH));
  assign pop_eff  = pop && valid;
  assign top_addr = stack_mem[top_reg];

  // If a push and a pop happen in the same cycle, the new address replaces
  // the top entry. A plain push writes one slot above the top.
  assign wr_ptr = pop_eff ? top_reg : top_reg + 1'b1;

  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    if (push && !pop_eff) begin
      top_next = top_reg + 1'b1;
      if (!full) count_next = count_reg + 1'b1;
    end else if (pop_eff && !push) begin
      top_next   = top_reg - 1'b1;
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      top_reg   <= '0;
      count_reg <= '0;
    end else begin
      top_reg   <= top_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !srst) stack_mem[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/bimodal_btb_predictor.sv
// Direct-mapped BTB with a per-entry saturating direction counter.
// Fetch reads it combinationally, and branch resolution writes it.
//   CLK, RST          : clock and synchronous active-high reset (starts init sweep)
//   flush             : restart the init sweep and invalidate all entries
//   ready             : sweep finished; lookups and updates are live
//   current_pc        : fetch PC to look up
//   predict_taken     : predicted taken for current_pc
//   target_addr       : predicted target (0 when not predicted taken)
//   update_predictor  : a resolved branch or jump is presented this cycle
//   pc_to_update, branch_result, update_addr, is_jump : resolution details
//   ras_push, ras_push_addr, ras_pop : return-stack controls
// Optional macro BTB_RAS_EN: builds a RAS_DEPTH-deep return stack. While the
// stack holds an entry, its top overrides the BTB on ras_pop. Without the
// macro, the ras_* inputs are ignored.
module bimodal_btb_predictor
  import branch_pred_pkg::*;
#(
  parameter int NUM_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int INDEX_LSB   = 2,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  output logic        ready,
  input  logic [31:0] current_pc,
  output logic        predict_taken,
  output logic [31:0] target_addr,
  input  logic        update_predictor,
  input  logic [31:0] pc_to_update,
  input  logic        branch_result,
  input  logic [31:0] update_addr,
  input  logic        is_jump,
  input  logic        ras_push,
  input  logic [31:0] ras_push_addr,
  input  logic        ras_pop
);

  localparam int IDX_BITS = $clog2(NUM_ENTRIES);
  localparam int TAG_LSB  = INDEX_LSB + IDX_BITS;
  localparam logic [CTR_MAX_BITS-1:0] CTR_ONES = ctr_ones(CTR_BITS);
  localparam logic [CTR_MAX_BITS-1:0] CTR_WEAK = weak_taken(CTR_BITS);

  bp_state_t           state_reg, state_next;
  logic [IDX_BITS-1:0] sweep_idx_reg, sweep_idx_next;
  logic                running;

  btb_entry_t btb_mem [NUM_ENTRIES];

  assign running = (state_reg == RUN);
  assign ready   = running;

  // ---------------- sweep / run state machine ----------------
  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    if (flush) begin
      state_next     = INIT;
      sweep_idx_next = '0;
    end else if (state_reg == INIT) begin
      sweep_idx_next = sweep_idx_reg + 1'b1;
      if (sweep_idx_reg == IDX_BITS'(NUM_ENTRIES - 1)) state_next = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= INIT;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  // ---------------- lookup (combinational) ----------------
  logic [IDX_BITS-1:0] lk_idx;
  logic [31:0]         lk_tag;
  logic                lk_hit, btb_taken;

  assign lk_idx    = current_pc[INDEX_LSB +: IDX_BITS];
  assign lk_tag    = current_pc >> TAG_LSB;
  assign lk_hit    = btb_mem[lk_idx].valid && (btb_mem[lk_idx].tag == lk_tag);
  assign btb_taken = lk_hit && (btb_mem[lk_idx].jump || btb_mem[lk_idx].ctr[CTR_BITS-1]);

  // ---------------- update / sweep write port ----------------
  logic [IDX_BITS-1:0] up_idx;
  logic [31:0]         up_tag;
  btb_entry_t          up_entry;
  logic                up_hit;

  assign up_idx   = pc_to_update[INDEX_LSB +: IDX_BITS];
  assign up_tag   = pc_to_update >> TAG_LSB;
  assign up_entry = btb_mem[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  btb_entry_t          wr_entry;

  // One write port is shared between the init sweep and resolution updates.
  // The two never coincide, because updates are only accepted in RUN.
  // Flush takes priority and drops a same-cycle update.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = sweep_idx_reg;
    wr_entry = '0;
    if (!RST && !flush) begin
      if (state_reg == INIT) begin
        wr_en = 1'b1;
      end else if (update_predictor) begin
        wr_idx = up_idx;
        if (up_hit) begin
          wr_en    = 1'b1;
          wr_entry = up_entry;
          if (is_jump) begin
            wr_entry.jump   = 1'b1;
            wr_entry.ctr    = CTR_ONES;
            wr_entry.target = update_addr;
          end else if (branch_result) begin
            if (up_entry.ctr != CTR_ONES) wr_entry.ctr = up_entry.ctr + CTR_MAX_BITS'(1);
            wr_entry.target = update_addr;
          end else begin
            if (up_entry.ctr != '0) wr_entry.ctr = up_entry.ctr - CTR_MAX_BITS'(1);
          end
        end else if (branch_result || is_jump) begin
          // Allocate, evicting whatever else maps to this index.
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.jump   = is_jump;
          wr_entry.tag    = up_tag;
          wr_entry.target = update_addr;
          wr_entry.ctr    = is_jump ? CTR_ONES : CTR_WEAK;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) btb_mem[wr_idx] <= wr_entry;
  end

  // ---------------- optional return stack ----------------
  logic        ras_hit;
  logic [31:0] ras_top;
  logic        unused_bits;

`ifdef BTB_RAS_EN
  logic ras_valid;

  return_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (CLK),
    .srst      (RST | flush),
    .push      (ras_push & running),
    .pop       (ras_pop & running),
    .push_addr (ras_push_addr),
    .valid     (ras_valid),
    .top_addr  (ras_top)
  );

  assign ras_hit     = ras_pop && ras_valid;
  assign unused_bits = ^{current_pc, pc_to_update};
`else
  assign ras_hit     = 1'b0;
  assign ras_top     = '0;
  assign unused_bits = ^{current_pc, pc_to_update, ras_push, ras_push_addr, ras_pop};
`endif

  // ---------------- prediction outputs ----------------
  always_comb begin
    predict_taken = 1'b0;
    target_addr   = '0;
    if (running) begin
      if (ras_hit) begin
        predict_taken = 1'b1;
        target_addr   = ras_top;
      end else if (btb_taken) begin
        predict_taken = 1'b1;
        target_addr   = btb_mem[lk_idx].target;
      end
    end
  end

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Directed bench for bimodal_btb_predictor (64 entries, 2-bit counters,
// INDEX_LSB=2). The driver pushes hand-computed expectations into a queue.
// A monitor on the falling edge pops each expectation and compares it with
// the DUT outputs presented during that cycle.
module tb_bimodal_btb_predictor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        ready;
    logic [31:0] current_pc = '0;
    logic        predict_taken;
    logic [31:0] target_addr;
    logic        update_predictor = 1'b0;
    logic [31:0] pc_to_update = '0;
    logic        branch_result = 1'b0;
    logic [31:0] update_addr = '0;
    logic        is_jump = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        ras_pop = 1'b0;

    always #5 CLK = ~CLK;

    bimodal_btb_predictor #(
        .NUM_ENTRIES (64),
        .CTR_BITS    (2),
        .INDEX_LSB   (2),
        .RAS_DEPTH   (8)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .flush            (flush),
        .ready            (ready),
        .current_pc       (current_pc),
        .predict_taken    (predict_taken),
        .target_addr      (target_addr),
        .update_predictor (update_predictor),
        .pc_to_update     (pc_to_update),
        .branch_result    (branch_result),
        .update_addr      (update_addr),
        .is_jump          (is_jump),
        .ras_push         (ras_push),
        .ras_push_addr    (ras_push_addr),
        .ras_pop          (ras_pop)
    );

    typedef struct {
        string       name;
        logic        rdy;
        logic        tkn;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (ready !== mon_e.rdy || predict_taken !== mon_e.tkn || target_addr !== mon_e.tgt) begin
                errors++;
                $display("FAIL %s: got ready=%0b taken=%0b target=%h, expected ready=%0b taken=%0b target=%h",
                         mon_e.name, ready, predict_taken, target_addr, mon_e.rdy, mon_e.tkn, mon_e.tgt);
            end else begin
                $display("ok   %s: ready=%0b taken=%0b target=%h", mon_e.name, ready, predict_taken, target_addr);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string n, input logic r, input logic t, input logic [31:0] a);
        exp_q.push_back('{name: n, rdy: r, tkn: t, tgt: a});
    endtask

    task automatic look(input string n, input logic [31:0] pc, input logic t, input logic [31:0] a);
        current_pc = pc;
        expect_out(n, 1'b1, t, a);
        tick();
    endtask

    task automatic upd(input logic [31:0] pc, input logic res, input logic [31:0] addr, input logic jmp);
        update_predictor = 1'b1;
        pc_to_update     = pc;
        branch_result    = res;
        update_addr      = addr;
        is_jump          = jmp;
        tick();
        update_predictor = 1'b0;
        branch_result    = 1'b0;
        is_jump          = 1'b0;
    endtask

    task automatic check_ready(input string n);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: ready=%0b, expected 1", n, ready);
        end else begin
            $display("ok   %s: ready=%0b", n, ready);
        end
    endtask

    task automatic init_wait(input string n, input bit inj);
        for (int i = 0; i <= 64; i++) begin
            expect_out($sformatf("%s_c%0d", n, i), (i == 64), 1'b0, 32'h0);
            if (inj && i == 10) begin
                update_predictor = 1'b1;
                pc_to_update     = 32'h20C;
                branch_result    = 1'b1;
                update_addr      = 32'h400;
            end
            tick();
            update_predictor = 1'b0;
            branch_result    = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        current_pc = 32'h100;
        init_wait("rst_init", 1'b0);
        check_ready("rst_ready_held");

        look("miss_0x100", 32'h100, 1'b0, 32'h0);
        current_pc = 32'h100;
        expect_out("same_cycle_old", 1'b1, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        look("alloc_hit", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("nt1", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("nt2", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("nt3_sat0", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h220, 1'b0);
        look("t_from0", 32'h100, 1'b0, 32'h0);
        current_pc = 32'h100;
        expect_out("same_cycle_old2", 1'b1, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h240, 1'b0);
        look("t_to2", 32'h100, 1'b1, 32'h240);
        upd(32'h100, 1'b1, 32'h240, 1'b0);
        upd(32'h100, 1'b1, 32'h260, 1'b0);
        look("sat3", 32'h100, 1'b1, 32'h260);
        upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("nt_keep_tgt", 32'h100, 1'b1, 32'h260);

        upd(32'h500, 1'b1, 32'h600, 1'b0);
        look("alias_old_miss", 32'h100, 1'b0, 32'h0);
        look("alias_new_hit", 32'h500, 1'b1, 32'h600);
        upd(32'h700, 1'b0, 32'h777, 1'b0);
        look("nt_noalloc", 32'h700, 1'b0, 32'h0);
        look("occupant_kept", 32'h500, 1'b1, 32'h600);

        upd(32'h300, 1'b1, 32'h40, 1'b1);
        look("jump_hit", 32'h300, 1'b1, 32'h40);
        for (int k = 1; k <= 3; k++) begin
            upd(32'h300, 1'b0, 32'h999, 1'b0);
            look($sformatf("jump_nt%0d", k), 32'h300, 1'b1, 32'h40);
        end
        look("jump_evicted_0x500", 32'h500, 1'b0, 32'h0);

        upd(32'h104, 1'b1, 32'h900, 1'b0);
        look("idx1_hit", 32'h104, 1'b1, 32'h900);
        look("tag_mismatch", 32'h8000_0104, 1'b0, 32'h0);
        look("idx0_untouched", 32'h300, 1'b1, 32'h40);
        upd(32'h104, 1'b0, 32'h0, 1'b0);
        look("idx1_weak_nt", 32'h104, 1'b0, 32'h0);
        upd(32'h104, 1'b0, 32'h800, 1'b1);
        look("hit_to_jump", 32'h104, 1'b1, 32'h800);
        upd(32'h104, 1'b0, 32'h0, 1'b0);
        look("hit_jump_nt", 32'h104, 1'b1, 32'h800);

        current_pc = 32'h300;
        expect_out("flush_cycle", 1'b1, 1'b1, 32'h40);
        flush = 1'b1;
        upd(32'h208, 1'b1, 32'h300, 1'b0);
        flush = 1'b0;
        init_wait("flush_init", 1'b1);
        check_ready("flush_ready_held");
        look("flushed_0x300", 32'h300, 1'b0, 32'h0);
        look("flushed_upd_dropped", 32'h208, 1'b0, 32'h0);
        look("init_upd_ignored", 32'h20C, 1'b0, 32'h0);

        upd(32'h104, 1'b1, 32'h900, 1'b0);
`ifdef BTB_RAS_EN
        ras_push = 1'b1;
        ras_push_addr = 32'h10;
        tick();
        ras_push_addr = 32'h20;
        tick();
        ras_push = 1'b0;
        current_pc = 32'h104;
        ras_pop = 1'b1;
        expect_out("ras_pop_0x20", 1'b1, 1'b1, 32'h20);
        tick();
        expect_out("ras_pop_0x10", 1'b1, 1'b1, 32'h10);
        tick();
        expect_out("ras_empty_fallback", 1'b1, 1'b1, 32'h900);
        tick();
        ras_pop = 1'b0;
        ras_push = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            ras_push_addr = 32'h1000 + 32'(4 * k);
            tick();
        end
        ras_push = 1'b0;
        ras_pop = 1'b1;
        for (int k = 9; k >= 2; k--) begin
            expect_out($sformatf("ras_ovf_pop%0d", k), 1'b1, 1'b1, 32'h1000 + 32'(4 * k));
            tick();
        end
        expect_out("ras_ovf_oldest_lost", 1'b1, 1'b1, 32'h900);
        tick();
        ras_pop = 1'b0;
        ras_push = 1'b1;
        ras_push_addr = 32'hA0;
        tick();
        ras_pop = 1'b1;
        ras_push_addr = 32'hB0;
        expect_out("ras_pushpop_old_top", 1'b1, 1'b1, 32'hA0);
        tick();
        ras_push = 1'b0;
        expect_out("ras_replaced_top", 1'b1, 1'b1, 32'hB0);
        tick();
        expect_out("ras_replaced_empty", 1'b1, 1'b1, 32'h900);
        tick();
        ras_pop = 1'b0;
`else
        ras_push = 1'b1;
        ras_push_addr = 32'h10;
        tick();
        ras_push = 1'b0;
        current_pc = 32'h104;
        ras_pop = 1'b1;
        expect_out("ras_ignored", 1'b1, 1'b1, 32'h900);
        tick();
        ras_pop = 1'b0;
`endif

        tick();
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks: %0d", checks);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %0d expectations never checked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors == 0) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule
